// File: rtl/toggle_rx.sv
// Toggle-protocol receiver: synchronises an asynchronous toggle line, counts
// each level change as an event, returns an ack toggle, and queues events for a consumer.
module toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  output logic             ack_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic                   evt;
  logic                   pop;
  logic                   full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  // Either edge direction of the synchronised line is one event.
  assign evt  = sync_q[SYNC_STAGES-1] ^ hist;
  assign full = (cnt_q == CNT_MAX);

  // Handshake: evt_valid depends only on registered state (pending != 0);
  // a pop occurs on any rising edge where evt_valid and evt_ready are both
  // high; evt_ready is ignored while nothing is pending.
  assign pop = evt_valid & evt_ready;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (evt && !pop) begin
      // Listed after the clear so a simultaneous drop keeps the flag set.
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (pop && !evt) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign ack_out   = hist;
  assign evt_valid = (cnt_q != '0);
  assign pending   = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, meaning the synchronizer depth on tog_in (legal values 2..4).
REQ-002 SHALL provide parameter CNT_W, default 4, meaning the pending-counter width (capacity 2^CNT_W-1 events).
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL provide port tog_in, input, 1, the toggle line from the transmitting T flip-flop, asynchronous to clk; each level change is one event.
REQ-006 SHALL provide port ack_out, output, 1, the return toggle; it equals the last tog_in level consumed.
REQ-007 SHALL provide port evt_valid, output, 1, high while at least one event is pending.
REQ-008 SHALL provide port evt_ready, input, 1, consumer pop request.
REQ-009 SHALL provide port pending, output, CNT_W, the current pending-event count.
REQ-010 SHALL provide port overflow, output, 1, a sticky flag indicating a dropped event.
REQ-011 SHALL provide port clr_ovf, input, 1, a synchronous clear for overflow.

Function
REQ-012 SHALL pass tog_in through a chain of SYNC_STAGES flops, followed by one history flop (hist) loaded from the last stage every cycle.
REQ-013 SHALL detect an event when the last sync stage differs from hist (either edge direction).
REQ-014 SHALL drive ack_out directly from hist; ack_out therefore toggles on the same edge as the event is counted, whether or not the event is accepted.
REQ-015 Latency SHALL be as follows: for a tog_in change stable before capture edge 1, pending updates and ack_out toggles on edge SYNC_STAGES+1 (edge 3 at the default).
REQ-016 SHALL define a pop as evt_valid and evt_ready both high at a clock edge.
REQ-017 SHALL drive evt_valid as (pending != 0) from registered state only, with no combinational path from evt_ready or tog_in.
REQ-018 SHALL update the pending counter as follows:
  - event only, pending < max: pending + 1
  - pop only: pending - 1
  - event and pop together: unchanged
  - neither: unchanged
REQ-019 SHALL handle the full boundary as follows:
  - event with no pop at pending = 2^CNT_W-1: pending holds at max, the event is dropped, and overflow sets on that edge
  - event with pop at max: pending holds at max and overflow is not set
REQ-020 SHALL ignore evt_ready when pending = 0; there is no wrap below zero.
REQ-021 SHALL keep overflow at 1 until a clr_ovf edge clears it; if a set and clr_ovf occur on the same edge, the set wins.
REQ-022 SHALL hold tog_in to at most one level change per SYNC_STAGES+1 clk cycles as a transmitter obligation; a transmitter that waits for ack_out == its own level never violates this, and faster toggling may merge events.

Reset
REQ-023 While reset = 0, SHALL asynchronously clear all sync flops, hist, pending and overflow; outputs are then ack_out=0, evt_valid=0, pending=0 and overflow=0.
REQ-024 On reset release, SHALL treat a tog_in level of 1 as one genuine event, counted at edge SYNC_STAGES+1 (the transmitter T flip-flop resets to 0).
REQ-025 Reset asserted mid-operation SHALL discard pending events and any in-flight toggle immediately, with no glitch on outputs after release.

Verification
REQ-026 Single event: reset released, tog_in 0->1 before edge 1, evt_ready=0 -> pending=1, evt_valid=1 and ack_out=1 after edge 3, with nothing earlier.
REQ-027 Burst and drain: 5 toggles spaced 4 cycles apart, evt_ready=0 -> pending=5; then evt_ready=1 -> pending steps 4,3,2,1,0 on consecutive edges, evt_valid=0 after the fifth pop, and a sixth evt_ready cycle leaves pending at 0.
REQ-028 Overflow: 16 toggles spaced 4 cycles apart, evt_ready=0, CNT_W=4 -> pending=15 after the 15th event; the 16th event sets overflow=1, pending stays 15, and ack_out still toggles.
REQ-029 Simultaneous events: at pending=15, event plus pop on the same edge -> pending=15, overflow=0; at pending=3, event plus pop -> pending=3; clr_ovf and an overflowing event on the same edge -> overflow=1.
REQ-030 Reset behaviour: with pending=7 and overflow=1, assert reset mid-cycle -> all outputs 0 before the next edge; release with tog_in=1 -> pending=1 at edge 3.
REQ-031 Handshake loop: a model transmitter toggles only when ack_out equals its level, run for 200 events with random evt_ready -> overflow never sets and total pops equal 200.
